// File: rtl/msg_uart_tx.sv
// UART serializer: sends an 8*MSG_BYTES-bit frame MSB byte first as back-to-back 8N1 characters.
// Build option MSG_UART_PARITY_EN adds an even-parity bit after each character's data bits.
module msg_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MSG_BYTES    = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iTransmit,
  input  logic [8*MSG_BYTES-1:0] iMsg,
  output logic                   oTx,
  output logic                   oBusy,
  output logic                   oTxDone,
  output logic [3:0]             oByteIdx
);

  localparam int unsigned MSG_W     = 8 * MSG_BYTES;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(MSG_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MSG_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t           state, stateNext;
  logic [15:0]      baudCnt, baudNext;
  logic [2:0]       bitCnt, bitNext, bitInc;
  logic [MSG_W-1:0] shiftReg, shiftNext;
  logic [3:0]       idxNext;
  logic             txNext, busyNext, doneNext;
  logic [7:0]       curByte;
  logic             baudEnd;

  assign curByte = shiftReg[MSG_W-1 -: 8];
  assign baudEnd = (baudCnt == BAUD_LAST);
  assign bitInc  = bitCnt + 3'd1;

  // Outputs are registered from next-state values so the line level changes on the same edge as the state.
  always_comb begin
    stateNext = state;
    baudNext  = baudEnd ? '0 : baudCnt + 16'd1;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    idxNext   = oByteIdx;
    txNext    = oTx;
    busyNext  = oBusy;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        baudNext = '0;
        bitNext  = '0;
        idxNext  = '0;
        txNext   = 1'b1;
        busyNext = 1'b0;
        if (iTransmit) begin
          shiftNext = iMsg;
          stateNext = START;
          txNext    = 1'b0;
          busyNext  = 1'b1;
        end
      end
      START: begin
        if (baudEnd) begin
          stateNext = DATA;
          bitNext   = '0;
          txNext    = curByte[0];
        end
      end
      DATA: begin
        if (baudEnd) begin
          if (bitCnt == 3'd7) begin
`ifdef MSG_UART_PARITY_EN
            stateNext = PARITY;
            txNext    = ^curByte;
`else
            stateNext = STOP;
            txNext    = 1'b1;
`endif
          end else begin
            bitNext = bitInc;
            txNext  = curByte[bitInc];
          end
        end
      end
`ifdef MSG_UART_PARITY_EN
      PARITY: begin
        if (baudEnd) begin
          stateNext = STOP;
          txNext    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baudEnd) begin
          if (oByteIdx < IDX_LAST) begin
            // Next byte moves to the top of the shift register; start bit follows with no gap.
            idxNext   = oByteIdx + 4'd1;
            shiftNext = {shiftReg[MSG_W-9:0], 8'h00};
            stateNext = START;
            txNext    = 1'b0;
          end else begin
            stateNext = DONE;
            txNext    = 1'b1;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
        baudNext  = '0;
        idxNext   = '0;
        txNext    = 1'b1;
        busyNext  = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      oByteIdx <= '0;
      oTx      <= 1'b1;
      oBusy    <= 1'b0;
      oTxDone  <= 1'b0;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
      oByteIdx <= idxNext;
      oTx      <= txNext;
      oBusy    <= busyNext;
      oTxDone  <= doneNext;
    end
  end

endmodule

// File: tb/tb_msg_uart_tx.sv
// Bench for msg_uart_tx: frame table plus hand sequences; a line decoder checks every character against a byte scoreboard.
module tb_msg_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned NB  = 12;
`ifdef MSG_UART_PARITY_EN
  localparam int unsigned CHAR_BITS = 11;
`else
  localparam int unsigned CHAR_BITS = 10;
`endif
  localparam int unsigned FRAME_CYC = NB * CHAR_BITS * CPB;

  localparam logic [95:0] WR_MSG   = {8'h0F, 16'h0002, 32'hF0F0F0F0, 24'h00000F, 8'h00, 8'hF0};
  localparam logic [95:0] WR_BYTES = {8'h0F, 8'h00, 8'h02, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hF0};
  localparam logic [95:0] RD_MSG   = {8'h0F, 16'h0001, 32'h00000000, 24'hFFFFFF, 8'hFF, 8'hF0};
  localparam logic [95:0] RD_BYTES = {8'h0F, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0};

  logic        clk = 1'b0;
  logic        reset;
  logic        iTransmit;
  logic [95:0] iMsg;
  logic        oTx, oBusy, oTxDone;
  logic [3:0]  oByteIdx;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned doneCount = 0;
  always @(negedge clk) if (oTxDone) doneCount <= doneCount + 1;

  msg_uart_tx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(NB)) dut (
    .clk(clk), .reset(reset), .iTransmit(iTransmit), .iMsg(iMsg),
    .oTx(oTx), .oBusy(oBusy), .oTxDone(oTxDone), .oByteIdx(oByteIdx)
  );

  logic [7:0] sbQ[$];
  int unsigned mainChecks = 0, mainPass = 0, monChecks = 0, monPass = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    mainChecks++;
    if (act === exp) mainPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic monCheck(input string name, input logic [7:0] act, input logic [7:0] exp);
    monChecks++;
    if (act === exp) monPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBytes(input logic [95:0] bytes);
    for (int k = 0; k < int'(NB); k++) sbQ.push_back(bytes[8*(int'(NB)-k)-1 -: 8]);
  endtask

  // Line decoder: compares every cycle of each character against the expected bit and decodes at mid-bit.
  initial begin
    bit          active = 1'b0;
    bit          timingOk = 1'b1;
    int unsigned pos = 0;
    int unsigned slot;
    logic [7:0]  expByte = '0;
    logic [7:0]  got = '0;
    logic        expBit;
`ifdef MSG_UART_PARITY_EN
    logic        parBit = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else begin
        if (!active && oTx === 1'b0) begin
          active   = 1'b1;
          pos      = 0;
          timingOk = 1'b1;
          got      = '0;
          monCheck("sb_nonempty", 8'(sbQ.size() != 0), 8'd1);
          expByte = (sbQ.size() != 0) ? sbQ.pop_front() : 8'h00;
        end
        if (active) begin
          slot = pos / CPB;
          if (slot == 0) expBit = 1'b0;
          else if (slot <= 8) expBit = expByte[3'(slot-1)];
`ifdef MSG_UART_PARITY_EN
          else if (slot == 9) expBit = ^expByte;
`endif
          else expBit = 1'b1;
          if (oTx !== expBit) timingOk = 1'b0;
          if (pos % CPB == CPB / 2) begin
            if (slot >= 1 && slot <= 8) got[3'(slot-1)] = oTx;
`ifdef MSG_UART_PARITY_EN
            if (slot == 9) parBit = oTx;
`endif
          end
          if (pos == CHAR_BITS * CPB - 1) begin
            monCheck("char_byte", got, expByte);
            monCheck("char_bit_timing", 8'(timingOk), 8'd1);
`ifdef MSG_UART_PARITY_EN
            monCheck("parity_bit", 8'(parBit), 8'(^expByte));
`endif
            active = 1'b0;
          end
          pos++;
        end
      end
    end
  end

  typedef struct {
    logic [95:0] msg;
    logic [95:0] expBytes;
    bit          lateReq;
  } vec_t;

  vec_t vecs[3];

  // iTransmit goes high just after edge n; busy spans n+1..n+FRAME_CYC, done pulses at n+FRAME_CYC+1.
  task automatic runFrame(input vec_t v);
    int unsigned n, c, dones;
    bit busyOk, doneOk, idxOk;
    pushBytes(v.expBytes);
    @(posedge clk);
    #1;
    iMsg = v.msg;
    iTransmit = 1'b1;
    n = cyc;
    tick();
    iTransmit = 1'b0;
    iMsg = ~v.msg;
    busyOk = 1'b1; doneOk = 1'b1; idxOk = 1'b1; dones = 0;
    while (cyc < n + FRAME_CYC + 3) begin
      @(negedge clk);
      c = cyc - n;
      if (oBusy !== (c >= 1 && c <= FRAME_CYC)) busyOk = 1'b0;
      if (oTxDone === 1'b1) dones++;
      if (oTxDone !== (c == FRAME_CYC + 1)) doneOk = 1'b0;
      if (c >= 1 && c <= FRAME_CYC && oByteIdx !== 4'((c - 1) / (CHAR_BITS * CPB))) idxOk = 1'b0;
      if (v.lateReq && c == 100) begin iMsg = '1; iTransmit = 1'b1; end
      if (v.lateReq && c == 101) iTransmit = 1'b0;
    end
    check("busy_window", 96'(busyOk), 96'd1);
    check("done_timing", 96'(doneOk), 96'd1);
    check("done_count", 96'(dones), 96'd1);
    check("byte_idx", 96'(idxOk), 96'd1);
    check("idx_cleared", 96'(oByteIdx), 96'd0);
    check("tx_idle_after", 96'(oTx), 96'd1);
    check("sb_drained", 96'(sbQ.size()), 96'd0);
  endtask

  initial begin
    int unsigned n, c, dones, doneBefore;
    bit idleOk, busyOk, doneOk;

    vecs[0] = '{msg: WR_MSG, expBytes: WR_BYTES, lateReq: 1'b0};
    vecs[1] = '{msg: WR_MSG, expBytes: WR_BYTES, lateReq: 1'b1};
    vecs[2] = '{msg: RD_MSG, expBytes: RD_BYTES, lateReq: 1'b0};

    reset = 1'b1; iTransmit = 1'b0; iMsg = '0;
    repeat (3) tick();
    check("rst_tx", 96'(oTx), 96'd1);
    check("rst_busy", 96'(oBusy), 96'd0);
    check("rst_done", 96'(oTxDone), 96'd0);
    check("rst_idx", 96'(oByteIdx), 96'd0);
    reset = 1'b0;
    idleOk = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (oTx !== 1'b1 || oBusy !== 1'b0 || oTxDone !== 1'b0) idleOk = 1'b0;
    end
    check("reset_idle", 96'(idleOk), 96'd1);

    for (int i = 0; i < 3; i++) runFrame(vecs[i]);

    // Reset in the middle of the second character, while the line is low.
    pushBytes(WR_BYTES);
    @(posedge clk);
    #1;
    iMsg = WR_MSG; iTransmit = 1'b1; n = cyc;
    tick();
    iTransmit = 1'b0;
    while (cyc < n + 50) tick();
    check("pre_reset_tx", 96'(oTx), 96'd0);
    reset = 1'b1;
    #1;
    check("async_reset_tx", 96'(oTx), 96'd1);
    check("async_reset_busy", 96'(oBusy), 96'd0);
    sbQ.delete();
    doneBefore = doneCount;
    repeat (3) tick();
    reset = 1'b0;
    repeat (FRAME_CYC) @(negedge clk);
    check("no_done_after_abort", 96'(doneCount - doneBefore), 96'd0);
    runFrame(vecs[2]);

    // iTransmit held high through DONE: second frame (new iMsg) accepted at edge n+FRAME_CYC+2.
    pushBytes(WR_BYTES);
    pushBytes(RD_BYTES);
    @(posedge clk);
    #1;
    iMsg = WR_MSG; iTransmit = 1'b1; n = cyc;
    busyOk = 1'b1; doneOk = 1'b1; dones = 0;
    while (cyc < n + 2 * FRAME_CYC + 5) begin
      @(negedge clk);
      c = cyc - n;
      if (c == 10) iMsg = RD_MSG;
      if (oBusy !== ((c >= 1 && c <= FRAME_CYC) || (c >= FRAME_CYC + 3 && c <= 2 * FRAME_CYC + 2))) busyOk = 1'b0;
      if (oTxDone === 1'b1) dones++;
      if (oTxDone !== (c == FRAME_CYC + 1 || c == 2 * FRAME_CYC + 3)) doneOk = 1'b0;
      if (c == FRAME_CYC + 3) iTransmit = 1'b0;
    end
    check("hold_busy_window", 96'(busyOk), 96'd1);
    check("hold_done_timing", 96'(doneOk), 96'd1);
    check("hold_done_count", 96'(dones), 96'd2);
    check("hold_sb_drained", 96'(sbQ.size()), 96'd0);

    repeat (10) tick();
    $display("%0d/%0d checks passed", mainPass + monPass, mainChecks + monChecks);
    $finish;
  end

endmodule
